// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation codes, default latencies and the IDLE/RUN state type.
// Decode logic in E_ctrl imports the same op codes.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath: op, A, B -> {hi, lo} plus a divide-by-zero flag.
// One shared multiplier (sign-extended or zero-extended inputs) and one shared magnitude divider.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        is_signed_mul;
    logic        is_signed_div;
    logic        b_zero;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quot;
    logic [31:0] rem;

    assign is_signed_mul = (op == MDU_MULT);
    assign is_signed_div = (op == MDU_DIV);
    assign b_zero        = (b == 32'd0);

    assign mul_a   = {{32{is_signed_mul & a[31]}}, a};
    assign mul_b   = {{32{is_signed_mul & b[31]}}, b};
    assign product = mul_a * mul_b;

    // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign div_n = is_signed_div ? abs_a : a;
    assign div_d = b_zero ? 32'd1 : (is_signed_div ? abs_b : b);
    assign mag_q = div_n / div_d;
    assign mag_r = div_n % div_d;

    assign quot = (is_signed_div && (a[31] ^ b[31])) ? (~mag_q + 32'd1) : mag_q;
    assign rem  = (is_signed_div && a[31])           ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: result = product;
            MDU_DIV, MDU_DIVU: begin
                result      = {rem, quot};
                div_by_zero = b_zero;
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns architectural HI/LO and the Busy flag.
// mult/div results are computed at accept and held in pending regs until the latency expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    logic             pend_dbz_reg, pend_dbz_next;

    logic [63:0]      calc_result;
    logic             calc_dbz;

    e_mdu_calc u_calc (
        .op          (E_MDUOp),
        .a           (E_RS),
        .b           (E_RT),
        .result      (calc_result),
        .div_by_zero (calc_dbz)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        pend_hi_next  = pend_hi_reg;
        pend_lo_next  = pend_lo_reg;
        pend_dbz_next = pend_dbz_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (E_Start) begin
                    case (E_MDUOp)
                        MDU_MTHI: hi_next = E_RS;
                        MDU_MTLO: lo_next = E_RS;
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            pend_hi_next  = calc_result[63:32];
                            pend_lo_next  = calc_result[31:0];
                            pend_dbz_next = calc_dbz;
                            cnt_next      = ((E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_MULTU))
                                            ? CNT_MULT : CNT_DIV;
                            state_next    = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Start strobes are ignored here; the last count edge commits.
                if (cnt_reg == CNT_ONE) begin
                    if (!pend_dbz_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            pend_hi_reg  <= 32'd0;
            pend_lo_reg  <= 32'd0;
            pend_dbz_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            pend_hi_reg  <= pend_hi_next;
            pend_lo_reg  <= pend_lo_next;
            pend_dbz_reg <= pend_dbz_next;
        end
    end

    assign E_Busy = busy_reg;
    assign E_HI   = hi_reg;
    assign E_LO   = lo_reg;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It is the writer of the HI/LO pair that the writeback-stage mux reads for mfhi/mflo.
- Accepts mult/multu/div/divu/mthi/mtlo from E, computes with a fixed multi-cycle latency, and holds HI/LO as architectural registers.
- Exposes Busy so hazard logic can stall later md-class instructions in D.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (must be >=1)
- DIV_CYCLES, 10, Busy duration for div/divu (must be >=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- E_Start  in  1  one-cycle strobe: E_MDUOp is valid this cycle
- E_MDUOp  in  4  operation code (see package)
- E_RS  in  32  operand A (dividend / multiplicand / mthi-mtlo source)
- E_RT  in  32  operand B (divisor / multiplier)
- E_Busy  out  1  registered; high while a mult/div is in flight
- E_HI  out  32  registered architectural HI
- E_LO  out  32  registered architectural LO

Behaviour:
- Reset (synchronous, active-high, dominates everything): E_HI=0, E_LO=0, E_Busy=0, counter=0, pending result regs=0. An in-flight op is discarded; HI/LO are not updated.
- Accept rule: an op is accepted when E_Start=1, E_Busy=0 and E_MDUOp!=MDU_NONE.
  - E_Start while E_Busy=1 is ignored entirely. Hazard logic guarantees this never happens; the bench still checks it.
  - E_Start with MDU_NONE or an undefined code: no effect.
- MTHI/MTLO: accepted at edge t, so E_HI (or E_LO) = E_RS from cycle t+1. E_Busy stays 0.
- MULT/MULTU/DIV/DIVU accepted at edge t:
  - Compute result combinationally from E_RS/E_RT and latch it into pending regs.
  - Load counter = N (MULT_CYCLES or DIV_CYCLES) and set E_Busy=1.
  - States: IDLE (Busy=0) and RUN (Busy=1, counter 1..N).
  - In RUN, each edge decrements the counter. On the edge where counter==1: commit pending to E_HI/E_LO, E_Busy<=0, return to IDLE.
  - Net timing: E_Busy is high for exactly N cycles (t+1..t+N). New HI/LO are visible from cycle t+N+1, the same cycle E_Busy is first low.
  - A new op may be accepted in cycle t+N+1.
  - E_HI/E_LO hold their old values throughout RUN.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=product[63:32], LO=product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
    - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (E_RT==0, div/divu): the op still runs the full DIV_CYCLES with Busy high, then commits with HI/LO left unchanged.
- Operands are sampled only at the accept edge. Later changes on E_RS/E_RT have no effect.
- Stall contract: hazard logic stalls D when the D instruction is md-class and (E_Start&&E_MDUOp is mult/div) || E_Busy. The block itself does not generate the E_Start term.

Decomposition:
- Shared constants header: MDU op codes (MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6), default MULT_CYCLES/DIV_CYCLES. E_ctrl decode imports the same codes.
- One natural sub-module: mdu_calc. It is combinational: op, A, B to 64-bit {hi,lo}, plus a div_by_zero flag.
- e_mdu keeps the counter, the Busy/IDLE-RUN logic, the pending regs and HI/LO.

Test Plan:
- Reset then MTHI with E_RS=0x12345678, then MTLO with E_RS=0x9ABCDEF0 on consecutive cycles -> E_HI=0x12345678 from the cycle after the first strobe, E_LO=0x9ABCDEF0 one cycle later, E_Busy never asserted.
- MULT E_RS=0xFFFFFFFE (-2), E_RT=3 -> E_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV E_RS=-7 (0xFFFFFFF9), E_RT=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- Preload HI=0xAAAA0000, LO=0x0000BBBB; DIVU with E_RT=0 -> Busy 10 cycles, then HI/LO unchanged.
- During a MULT in RUN: pulse E_Start with MDU_MTLO E_RS=0xDEAD and change E_RS/E_RT -> MTLO ignored, final HI/LO match the originally sampled operands, Busy length still 5.
- Assert reset at cycle 3 of a DIV -> next cycle E_Busy=0, HI=LO=0; a MULT accepted immediately after completes normally in 5 cycles.
